// File: rtl/rocket_mem_sched_pkg.sv
// Shared types and helpers for the AXI-to-word-memory scheduler and its arbiter.
package rocket_mem_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_CAP,
    RD_RESP,
    WR_BEAT,
    WR_RESP
  } sched_state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } grant_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int beat_bytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/rocket_rr_arb2.sv
// Two-way round-robin arbiter: requester 0 is the read side, requester 1 the write side.
module rocket_rr_arb2
  import rocket_mem_sched_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output grant_e     last_grant
);

  grant_e last_grant_reg;

  // On a tie the side that did not win last time goes first.
  always_comb begin
    gnt    = 2'b00;
    gnt[0] = en & req[0] & (~req[1] | (last_grant_reg == WRITE));
    gnt[1] = en & req[1] & (~req[0] | (last_grant_reg == READ));
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      last_grant_reg <= WRITE;
    end else if (gnt[0]) begin
      last_grant_reg <= READ;
    end else if (gnt[1]) begin
      last_grant_reg <= WRITE;
    end
  end

  assign last_grant = last_grant_reg;

endmodule

// File: rtl/rocket_axi_mem_sched.sv
// AXI4 INCR-burst scheduler onto a single-ported word memory with one-cycle read latency.
module rocket_axi_mem_sched
  import rocket_mem_sched_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clock,
  input  logic                    reset_wire_reset,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [ID_WIDTH-1:0]     aw_id,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic [7:0]              aw_len,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_last,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic [ID_WIDTH-1:0]     b_id,
  output logic [1:0]              b_resp,
  input  logic                    ar_valid,
  output logic                    ar_ready,
  input  logic [ID_WIDTH-1:0]     ar_id,
  input  logic [ADDR_WIDTH-1:0]   ar_addr,
  input  logic [7:0]              ar_len,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic [ID_WIDTH-1:0]     r_id,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [1:0]              r_resp,
  output logic                    r_last,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_strb_o,
  output logic [DATA_WIDTH-1:0]   mem_data_o,
  input  logic [DATA_WIDTH-1:0]   mem_data_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int BEAT_BYTES = beat_bytes(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] BEAT_INCR  = ADDR_WIDTH'(BEAT_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BEAT_BYTES - 1));

  sched_state_e          state_reg;
  logic [ID_WIDTH-1:0]   id_reg;
  logic [7:0]            len_reg;
  logic [7:0]            beat_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] r_data_reg;
  logic                  error_reg;

  logic [1:0] arb_gnt;
  logic       arb_en;
  grant_e     last_grant;
  logic       beat_final;
  logic       w_fire;
  logic       rd_issue;

  // Address channels are only offered while idle; reset keeps both readies low.
  assign arb_en = (state_reg == IDLE) & ~reset_wire_reset;

  rocket_rr_arb2 u_arb (
    .clk        (clock),
    .srst       (reset_wire_reset),
    .req        ({aw_valid, ar_valid}),
    .en         (arb_en),
    .gnt        (arb_gnt),
    .last_grant (last_grant)
  );

  assign ar_ready   = arb_gnt[0];
  assign aw_ready   = arb_gnt[1];
  assign beat_final = (beat_reg == len_reg);
  assign w_ready    = (state_reg == WR_BEAT);
  assign w_fire     = w_ready & w_valid;
  assign rd_issue   = (state_reg == RD_REQ);

  always_ff @(posedge clock) begin
    if (reset_wire_reset) begin
      state_reg  <= IDLE;
      id_reg     <= '0;
      len_reg    <= '0;
      beat_reg   <= '0;
      addr_reg   <= '0;
      r_data_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ar_ready) begin
            id_reg    <= ar_id;
            len_reg   <= ar_len;
            addr_reg  <= ar_addr & ALIGN_MASK;
            beat_reg  <= '0;
            state_reg <= RD_REQ;
          end else if (aw_ready) begin
            id_reg    <= aw_id;
            len_reg   <= aw_len;
            addr_reg  <= aw_addr & ALIGN_MASK;
            beat_reg  <= '0;
            error_reg <= 1'b0;
            state_reg <= WR_BEAT;
          end
        end
        RD_REQ: state_reg <= RD_CAP;
        RD_CAP: begin
          r_data_reg <= mem_data_i;
          state_reg  <= RD_RESP;
        end
        RD_RESP: begin
          if (r_ready) begin
            if (beat_final) begin
              state_reg <= IDLE;
            end else begin
              beat_reg  <= beat_reg + 8'd1;
              addr_reg  <= addr_reg + BEAT_INCR;
              state_reg <= RD_REQ;
            end
          end
        end
        WR_BEAT: begin
          if (w_valid) begin
            // The beat count decides the burst end; a w_last disagreeing with it is an error.
            if (w_last != beat_final) error_reg <= 1'b1;
            beat_reg <= beat_reg + 8'd1;
            addr_reg <= addr_reg + BEAT_INCR;
            if (beat_final) state_reg <= WR_RESP;
          end
        end
        WR_RESP: if (b_ready) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign r_valid = (state_reg == RD_RESP);
  assign r_last  = r_valid & beat_final;
  assign r_id    = id_reg;
  assign r_data  = r_data_reg;
  assign r_resp  = RESP_OKAY;

  assign b_valid = (state_reg == WR_RESP);
  assign b_id    = id_reg;
  assign b_resp  = (b_valid & error_reg) ? RESP_SLVERR : RESP_OKAY;

  assign mem_req_o  = rd_issue | w_fire;
  assign mem_we_o   = w_fire;
  assign mem_addr_o = addr_reg;
  assign mem_data_o = w_fire ? w_data : '0;

  generate
    for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_strb
      assign mem_strb_o[gi] = rd_issue | (w_fire & w_strb[gi]);
    end
  endgenerate

endmodule

// File: doc/rocket_axi_mem_sched.md
Name: rocket_axi_mem_sched

Overview:
- Scheduler between the ChipTop AXI4 memory (or MMIO) master port and one single-ported word memory interface (req/we/addr/strb/data, read data returned one cycle after req).
- Arbitrates between read and write bursts with round-robin fairness, then sequences each INCR burst beat by beat.
- Generates R and B responses.
- One instance per AXI port; instantiated under rocket_mem_top.

Parameters:
ID_WIDTH, 4, AXI ID width
ADDR_WIDTH, 32, AXI and memory byte-address width
DATA_WIDTH, 64, beat and memory word width; the block handles beats of DATA_WIDTH/8 bytes

Ports:
clock  in  1  single clock
reset_wire_reset  in  1  synchronous, active-high reset
aw_valid/aw_ready  in/out  1/1  write address handshake
aw_id  in  ID_WIDTH  write ID
aw_addr  in  ADDR_WIDTH  burst start byte address
aw_len  in  8  beats-1
w_valid/w_ready  in/out  1/1  write data handshake
w_data  in  DATA_WIDTH  write beat
w_strb  in  DATA_WIDTH/8  byte enables
w_last  in  1  last beat marker
b_valid/b_ready  out/in  1/1  write response handshake
b_id  out  ID_WIDTH  echoed aw_id
b_resp  out  2  00 OKAY, 10 SLVERR
ar_valid/ar_ready  in/out  1/1  read address handshake
ar_id  in  ID_WIDTH  read ID
ar_addr  in  ADDR_WIDTH  burst start byte address
ar_len  in  8  beats-1
r_valid/r_ready  out/in  1/1  read data handshake
r_id  out  ID_WIDTH  echoed ar_id
r_data  out  DATA_WIDTH  read beat
r_resp  out  2  always 00
r_last  out  1  final beat
mem_req_o  out  1  memory access strobe, one access per cycle
mem_we_o  out  1  1 = write
mem_addr_o  out  ADDR_WIDTH  beat-aligned byte address
mem_strb_o  out  DATA_WIDTH/8  byte enables (all ones on reads)
mem_data_o  out  DATA_WIDTH  write data
mem_data_i  in  DATA_WIDTH  read data, valid in the cycle after a read req

Behaviour:
- Reset values:
  - State IDLE; all ready, valid and req outputs 0; data, addr, id and resp outputs 0.
  - last_grant = WRITE, so the first read/write tie goes to the read.
- Reset mid-burst abandons the burst; no R or B is emitted for it.
- States: IDLE, RD_REQ, RD_CAP, RD_RESP, WR_BEAT, WR_RESP.
- IDLE arbitration:
  - ar_ready = ar_valid & (!aw_valid | last_grant==WRITE).
  - aw_ready = aw_valid & (!ar_valid | last_grant==READ).
  - Exactly one address handshake per IDLE cycle. It latches id, len, addr aligned down to DATA_WIDTH/8, and beat counter = 0, and updates last_grant.
  - Next state is RD_REQ or WR_BEAT.
- Read path:
  - RD_REQ: mem_req_o=1, we=0, strb all ones, addr = current address; go to RD_CAP.
  - RD_CAP: capture mem_data_i into the r_data register; go to RD_RESP.
  - RD_RESP: r_valid=1, r_last = (beat==len); outputs stay stable until r_ready.
  - On the R handshake: if last, go to IDLE; else increment beat and address, go to RD_REQ.
  - Latency: AR handshake at cycle T gives mem_req at T+1 and r_valid from T+3. Throughput is one beat per 3 cycles.
- Write path:
  - WR_BEAT: w_ready=1.
  - When w_valid, in the same cycle: mem_req_o=1, we=1, addr = current address, strb = w_strb, data = w_data. Then increment beat and address.
  - The burst ends on the beat where beat==len, regardless of w_last; then go to WR_RESP.
  - Set a sticky error flag if w_last is asserted on a non-final beat, or deasserted on the final beat.
  - An all-zero w_strb still issues mem_req_o with strb 0.
- WR_RESP: b_valid=1, b_resp = error ? 10 : 00, b_id = latched id; go to IDLE on b_ready.
- Address arithmetic: increment by DATA_WIDTH/8, modulo 2^ADDR_WIDTH (wraps at the top). No 4 KiB boundary check.
- Only INCR bursts; lock/cache/prot/qos/size/burst fields are not consumed (tied off at the instantiating level).
- No outstanding overlap: a new AR/AW is accepted only in IDLE.

Decomposition:
- Package rocket_mem_sched_pkg holds:
  - the state enum;
  - AXI resp constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the grant enum {READ, WRITE};
  - a function beat_bytes(DATA_WIDTH).
- Sub-module rocket_rr_arb2: 2-way round-robin arbiter (req[1:0], en, gnt one-hot, last_grant register), reused by future shared-port blocks.

Test Plan:
- Read single: ar_addr=0x80000013, len=0, id=5; mem returns 0xDEADBEEF_CAFEF00D -> mem_addr 0x80000010, r_data matches, r_last=1, r_id=5, r_valid at T+3.
- Read burst with backpressure: len=3 at 0x80000000, r_ready low for 4 cycles on beat 1 -> mem addrs 0x...00/08/10/18 in order, r_data stable while stalled, r_last only on beat 3.
- Write burst: aw len=1 at 0x80000100, w beats with strb 0xFF then 0x0F and w_last on beat 1 -> two mem writes at 0x100 and 0x108 with matching strb, then b_resp=00.
- Tie fairness: aw_valid and ar_valid held together for 4 bursts after reset -> grants alternate R, W, R, W.
- Error and wrap: aw_addr=0xFFFFFFF8, len=1, w_last asserted on beat 0 -> second mem addr 0x00000000, b_resp=10.
- Reset in RD_RESP -> next cycle r_valid=0, state IDLE, last_grant=WRITE; a new AR is accepted normally.
